washing_machine_ctrl: RTL and testbench
=======================================

Name: washing_machine_ctrl

Overview:
- Front-panel controller FSM for a washing machine: program and water-level selection, start/pause, timed wash/rinse/dry sequencing, countdown display values, and a finish buzzer with auto power-off.
- Sits between debounced panel buttons and the LED/display drivers.
- All time is in "units" derived from the system clock by an internal prescaler.

Parameters:
- UNIT_CYCLES, 4: clock cycles per time unit (1 s in silicon; small for simulation).
- BUZZ_UNITS, 3: buzzer duration after completion, in units.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start_pause, input, 1: level button; each rising edge is one press.
- module_select, input, 1: level button; each rising edge advances the program.
- water_select, input, 1: level button; each rising edge advances the water level.
- power_led, output, 1: machine powered.
- start_led, output, 1: program running (not paused).
- wash_led, output, 1: wash segment active.
- rinse_led, output, 1: rinse segment active.
- dry_led, output, 1: dry segment active.
- in_led, output, 1: water filling.
- out_led, output, 1: water draining.
- state, output, 3: FSM state. IDLE=0, FILL=1, WASH=2, RINSE=3, DRAIN=4, DRY=5, DONE=6, OFF=7.
- count, output, 6: units remaining in the current step.
- buzzer_led, output, 1: finish buzzer.
- water_level, output, 4: selected level L, one of {2, 4, 6, 8}.
- model_now, output, 3: selected program, 0..4.
- time_now, output, 6: units remaining in the whole program.
- time_all, output, 6: total program duration.
- power_off, output, 1: machine has shut down.
- if_finish, output, 1: program complete.

Behaviour:
- Reset (asynchronous, while reset=0):
  - state=IDLE, model_now=0, water_level=4, power_led=1, power_off=0.
  - All other LEDs, if_finish and count are 0.
  - Button edge-detect registers and the prescaler are cleared.
- Button edges: each button is registered once; press = current 1 and previous 0. A button already high at reset release counts as a press on the first clock.
- Programs (model_now) and their segments:
  - 0: wash, rinse, dry.
  - 1: wash only.
  - 2: wash, rinse.
  - 3: rinse, dry.
  - 4: dry only.
- Segment steps and durations:
  - Wash segment: FILL for L units, WASH for 6, DRAIN for L.
  - Rinse segment: FILL for L, RINSE for 4, DRAIN for L.
  - Dry segment: DRY for 3.
- time_all is combinational from model_now and L:
  - Program 0: 4L+13. Program 1: 2L+6. Program 2: 4L+10. Program 3: 2L+7. Program 4: 3.
- IDLE:
  - module_select press cycles model_now 0→1→2→3→4→0.
  - water_select press cycles L 2→4→6→8→2.
  - time_now = time_all; count = 0.
  - start_pause press: enter the first step of the program on that clock edge, load count with the step duration, clear the prescaler, set start_led=1.
  - If start_pause and a select press occur on the same edge, start wins and the select press is dropped.
- Running:
  - Selections are locked and select presses are ignored.
  - The prescaler counts clocks; every UNIT_CYCLES-th clock is a tick.
  - On a tick, count and time_now each decrement by 1.
  - A tick with count==1 advances to the next step and loads its duration instead.
  - Segment LEDs: wash_led is high through all wash-segment steps, rinse_led through all rinse-segment steps, dry_led during DRY.
  - in_led is high during FILL; out_led is high during DRAIN.
- Pause:
  - start_pause press while running toggles paused/running; start_led shows running.
  - While paused, the prescaler, count and time_now freeze and the step LEDs hold.
- Completion: after the last step, enter DONE.
  - time_now=0, if_finish=1, buzzer_led=1, start_led=0, segment and water LEDs off.
  - DONE lasts BUZZ_UNITS ticks, then the FSM enters OFF.
- OFF:
  - power_off=1, power_led=0, buzzer_led=0, if_finish stays 1.
  - All buttons are ignored; only reset leaves OFF.
  - start_pause presses are ignored in both DONE and OFF.
- Reset mid-run: immediately returns all registers to their reset values; no drain is performed.
- Arithmetic: all times fit in 6 bits (max 45); no wrap-around is possible.

Test Plan:
- Release reset with start_pause high from the start → start press on the first clock edge: state=FILL, in_led=1, wash_led=1, start_led=1, count=4, time_now=29, time_all=29.
- Program 0, L=4, no pauses → after each 4 clocks time_now decrements; step order FILL(4) WASH(6) DRAIN(4) FILL(4) RINSE(4) DRAIN(4) DRY(3); DONE at clock 116 with buzzer_led=1, if_finish=1; OFF 12 clocks later with power_off=1, power_led=0.
- In IDLE, module_select pressed 3 times and water_select once → model_now=3, water_level=6, time_all=19. Start → first step is rinse FILL with count=6. A further module_select press while running → no change.
- Program 4 running, press start_pause in DRY → start_led=0; time_now and count hold for 40 clocks; a second press resumes with no lost partial unit.
- Simultaneous module_select and start_pause press in IDLE with model_now=1 → starts program 1, time_all=14.
- Assert reset low mid-WASH → all outputs immediately at their reset values (state=0, model_now=0, water_level=4, power_led=1).

Source files
------------

// File: rtl/washing_machine_ctrl.sv
// Washing machine front-panel controller.
//
// Takes debounced panel buttons, lets the user pick a program and a water
// level while idle, then sequences fill/wash/rinse/drain/dry steps with a
// per-step countdown and a whole-program countdown.  When the program ends
// a buzzer sounds for BUZZ_UNITS time units and the machine powers itself off.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   start_pause    start / pause / resume button (level, rising edge = press)
//   module_select  program select button (level, rising edge = press)
//   water_select   water level select button (level, rising edge = press)
//   power_led, start_led, wash_led, rinse_led, dry_led, in_led, out_led,
//   buzzer_led     panel indicators
//   state          current step (IDLE=0 .. OFF=7)
//   count          units remaining in the current step
//   water_level    selected water level (2, 4, 6 or 8)
//   model_now      selected program (0..4)
//   time_now       units remaining in the whole program
//   time_all       total duration of the selected program
//   power_off      machine has shut itself down
//   if_finish      program has completed
module washing_machine_ctrl #(
  parameter int UNIT_CYCLES = 4,
  parameter int BUZZ_UNITS  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_pause,
  input  logic       module_select,
  input  logic       water_select,
  output logic       power_led,
  output logic       start_led,
  output logic       wash_led,
  output logic       rinse_led,
  output logic       dry_led,
  output logic       in_led,
  output logic       out_led,
  output logic [2:0] state,
  output logic [5:0] count,
  output logic       buzzer_led,
  output logic [3:0] water_level,
  output logic [2:0] model_now,
  output logic [5:0] time_now,
  output logic [5:0] time_all,
  output logic       power_off,
  output logic       if_finish
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    DRAIN = 3'd4,
    DRY   = 3'd5,
    DONE  = 3'd6,
    OFF   = 3'd7
  } state_t;

  localparam int            PW       = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(UNIT_CYCLES - 1);

  state_t        state_q, state_d;
  logic          rinse_seg_q, rinse_seg_d;
  logic          paused_q, paused_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [5:0]    count_q, count_d;
  logic [5:0]    time_q, time_d;
  logic [2:0]    model_q, model_d;
  logic [3:0]    level_q, level_d;
  logic          sp_q, ms_q, ws_q;

  logic   sp_press, ms_press, ws_press;
  logic   has_wash, has_rinse, has_dry;
  logic   running, pre_en, tick;
  logic   first_rinse, nxt_rinse;
  state_t first_state, nxt_state;
  logic [5:0] lvl6;

  assign sp_press = start_pause & ~sp_q;
  assign ms_press = module_select & ~ms_q;
  assign ws_press = water_select & ~ws_q;

  assign has_wash  = (model_q == 3'd0) || (model_q == 3'd1) || (model_q == 3'd2);
  assign has_rinse = (model_q == 3'd0) || (model_q == 3'd2) || (model_q == 3'd3);
  assign has_dry   = (model_q == 3'd0) || (model_q == 3'd3) || (model_q == 3'd4);

  assign lvl6    = {2'b00, level_q};
  assign running = state_q inside {FILL, WASH, RINSE, DRAIN, DRY};
  // The buzzer phase keeps the prescaler running so DONE can time itself out.
  assign pre_en  = (running && !paused_q) || (state_q == DONE);
  assign tick    = pre_en && (pre_q == PRE_LAST);

  function automatic logic [5:0] step_dur(input state_t s, input logic [5:0] lvl);
    case (s)
      FILL, DRAIN: step_dur = lvl;
      WASH:        step_dur = 6'd6;
      RINSE:       step_dur = 6'd4;
      DRY:         step_dur = 6'd3;
      DONE:        step_dur = 6'(BUZZ_UNITS);
      default:     step_dur = 6'd0;
    endcase
  endfunction

  always_comb begin
    time_all = 6'd3;
    case (model_q)
      3'd0:    time_all = (lvl6 << 2) + 6'd13;
      3'd1:    time_all = (lvl6 << 1) + 6'd6;
      3'd2:    time_all = (lvl6 << 2) + 6'd10;
      3'd3:    time_all = (lvl6 << 1) + 6'd7;
      default: time_all = 6'd3;
    endcase
  end

  // First step of the selected program.
  always_comb begin
    first_state = DRY;
    first_rinse = 1'b0;
    if (has_wash) begin
      first_state = FILL;
    end else if (has_rinse) begin
      first_state = FILL;
      first_rinse = 1'b1;
    end
  end

  // Step that follows the current one; FILL/DRAIN are shared by the wash and
  // rinse segments, so the segment flag decides where they lead.
  always_comb begin
    nxt_state = DONE;
    nxt_rinse = rinse_seg_q;
    case (state_q)
      FILL:        nxt_state = rinse_seg_q ? RINSE : WASH;
      WASH, RINSE: nxt_state = DRAIN;
      DRAIN: begin
        if (!rinse_seg_q && has_rinse) begin
          nxt_state = FILL;
          nxt_rinse = 1'b1;
        end else if (has_dry) begin
          nxt_state = DRY;
        end
      end
      DONE:    nxt_state = OFF;
      default: nxt_state = DONE;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rinse_seg_d = rinse_seg_q;
    paused_d    = paused_q;
    pre_d       = pre_q;
    count_d     = count_q;
    time_d      = time_q;
    model_d     = model_q;
    level_d     = level_q;
    case (state_q)
      IDLE: begin
        // Start takes priority; a select press on the same edge is dropped.
        if (sp_press) begin
          state_d     = first_state;
          rinse_seg_d = first_rinse;
          count_d     = step_dur(first_state, lvl6);
          time_d      = time_all;
          pre_d       = '0;
          paused_d    = 1'b0;
        end else begin
          if (ms_press) model_d = (model_q == 3'd4) ? 3'd0 : model_q + 3'd1;
          if (ws_press) level_d = (level_q == 4'd8) ? 4'd2 : level_q + 4'd2;
        end
      end
      OFF: ;
      default: begin
        if (pre_en) pre_d = tick ? '0 : pre_q + PW'(1);
        if (tick) begin
          if (count_q == 6'd1) begin
            state_d     = nxt_state;
            rinse_seg_d = nxt_rinse;
            count_d     = step_dur(nxt_state, lvl6);
          end else begin
            count_d = count_q - 6'd1;
          end
          if (running) time_d = time_q - 6'd1;
        end
        if (running && sp_press) paused_d = ~paused_q;
        // Pausing only means something while a step is active.
        if (state_d == DONE || state_d == OFF) paused_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rinse_seg_q <= 1'b0;
      paused_q    <= 1'b0;
      pre_q       <= '0;
      count_q     <= 6'd0;
      time_q      <= 6'd0;
      model_q     <= 3'd0;
      level_q     <= 4'd4;
      sp_q        <= 1'b0;
      ms_q        <= 1'b0;
      ws_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rinse_seg_q <= rinse_seg_d;
      paused_q    <= paused_d;
      pre_q       <= pre_d;
      count_q     <= count_d;
      time_q      <= time_d;
      model_q     <= model_d;
      level_q     <= level_d;
      sp_q        <= start_pause;
      ms_q        <= module_select;
      ws_q        <= water_select;
    end
  end

  assign state       = state_q;
  assign count       = count_q;
  assign water_level = level_q;
  assign model_now   = model_q;
  assign time_now    = (state_q == IDLE) ? time_all :
                       (running ? time_q : 6'd0);
  assign power_led   = (state_q != OFF);
  assign power_off   = (state_q == OFF);
  assign if_finish   = (state_q == DONE) || (state_q == OFF);
  assign buzzer_led  = (state_q == DONE);
  assign start_led   = running && !paused_q;
  assign wash_led    = (state_q == WASH) ||
                       (((state_q == FILL) || (state_q == DRAIN)) && !rinse_seg_q);
  assign rinse_led   = (state_q == RINSE) ||
                       (((state_q == FILL) || (state_q == DRAIN)) && rinse_seg_q);
  assign dry_led     = (state_q == DRY);
  assign in_led      = (state_q == FILL);
  assign out_led     = (state_q == DRAIN);

endmodule

// File: tb/tb_washing_machine_ctrl.sv
// Self-checking bench for washing_machine_ctrl.
// A reference model builds the step list of the chosen program as a queue and
// walks it unit by unit; the DUT outputs are compared with it every cycle
// under randomised button activity, pauses and mid-run resets.
module tb_washing_machine_ctrl;

  localparam int UNIT = 4;
  localparam int BUZZ = 3;

  localparam int S_IDLE = 0, S_FILL = 1, S_WASH = 2, S_RINSE = 3;
  localparam int S_DRAIN = 4, S_DRY = 5, S_DONE = 6, S_OFF = 7;

  typedef struct {
    int st;
    int dur;
    int seg;
  } step_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_pause = 1'b0;
  logic       module_select = 1'b0;
  logic       water_select = 1'b0;
  logic       power_led, start_led, wash_led, rinse_led, dry_led, in_led, out_led;
  logic [2:0] state;
  logic [5:0] count;
  logic       buzzer_led;
  logic [3:0] water_level;
  logic [2:0] model_now;
  logic [5:0] time_now, time_all;
  logic       power_off, if_finish;

  always #5 clk = ~clk;

  washing_machine_ctrl #(.UNIT_CYCLES(UNIT), .BUZZ_UNITS(BUZZ)) dut (
    .clk(clk), .reset(reset), .start_pause(start_pause),
    .module_select(module_select), .water_select(water_select),
    .power_led(power_led), .start_led(start_led), .wash_led(wash_led),
    .rinse_led(rinse_led), .dry_led(dry_led), .in_led(in_led), .out_led(out_led),
    .state(state), .count(count), .buzzer_led(buzzer_led),
    .water_level(water_level), .model_now(model_now), .time_now(time_now),
    .time_all(time_all), .power_off(power_off), .if_finish(if_finish)
  );

  int checks = 0;
  int errors = 0;

  int    mState, mModel, mLevel, mCount, mTime, mPre, mIdx;
  bit    mPaused, pSp, pMs, pWs;
  step_t steps[$];

  // Segment 0 = wash, 1 = rinse, 2 = dry.
  function automatic bit hasSeg(input int prog, input int seg);
    case (prog)
      0:       return 1'b1;
      1:       return seg == 0;
      2:       return seg < 2;
      3:       return seg > 0;
      default: return seg == 2;
    endcase
  endfunction

  function automatic int segTime(input int seg, input int lvl);
    if (seg == 0) return lvl + 6 + lvl;
    if (seg == 1) return lvl + 4 + lvl;
    return 3;
  endfunction

  function automatic int programTime(input int prog, input int lvl);
    int t = 0;
    for (int s = 0; s < 3; s++) if (hasSeg(prog, s)) t += segTime(s, lvl);
    return t;
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic pushStep(input int st, input int dur, input int seg);
    step_t e;
    e.st = st;
    e.dur = dur;
    e.seg = seg;
    steps.push_back(e);
  endtask

  task automatic modelReset();
    mState = S_IDLE; mModel = 0; mLevel = 4; mCount = 0; mTime = 0;
    mPre = 0; mIdx = 0; mPaused = 0; pSp = 0; pMs = 0; pWs = 0;
    steps.delete();
  endtask

  task automatic modelStep();
    bit psp, pms, pws, wasRun;
    psp = start_pause && !pSp;
    pms = module_select && !pMs;
    pws = water_select && !pWs;
    pSp = start_pause; pMs = module_select; pWs = water_select;
    if (mState == S_IDLE) begin
      if (psp) begin
        steps.delete();
        for (int s = 0; s < 3; s++) begin
          if (hasSeg(mModel, s)) begin
            if (s < 2) begin
              pushStep(S_FILL, mLevel, s);
              pushStep(s == 0 ? S_WASH : S_RINSE, s == 0 ? 6 : 4, s);
              pushStep(S_DRAIN, mLevel, s);
            end else begin
              pushStep(S_DRY, 3, 2);
            end
          end
        end
        pushStep(S_DONE, BUZZ, 3);
        pushStep(S_OFF, 0, 3);
        mIdx = 0;
        mState = steps[0].st;
        mCount = steps[0].dur;
        mTime = programTime(mModel, mLevel);
        mPre = 0;
        mPaused = 0;
      end else begin
        if (pms) mModel = (mModel + 1) % 5;
        if (pws) mLevel = (mLevel == 8) ? 2 : mLevel + 2;
      end
    end else if (mState != S_OFF) begin
      wasRun = (mState >= S_FILL) && (mState <= S_DRY);
      if (mState == S_DONE || !mPaused) begin
        mPre++;
        if (mPre == UNIT) begin
          mPre = 0;
          if (wasRun) mTime--;
          mCount--;
          if (mCount == 0) begin
            mIdx++;
            mState = steps[mIdx].st;
            mCount = steps[mIdx].dur;
          end
        end
      end
      if (wasRun && psp && mState <= S_DRY) mPaused = !mPaused;
      if (mState > S_DRY) mPaused = 0;
    end
  endtask

  task automatic checkAll(input string tag);
    bit run;
    int seg;
    run = (mState >= S_FILL) && (mState <= S_DRY);
    seg = run ? steps[mIdx].seg : 3;
    checkOutput({tag, ".state"}, int'(state), mState);
    checkOutput({tag, ".count"}, int'(count), mCount);
    checkOutput({tag, ".time_all"}, int'(time_all), programTime(mModel, mLevel));
    checkOutput({tag, ".time_now"}, int'(time_now),
                (mState == S_IDLE) ? programTime(mModel, mLevel) : (run ? mTime : 0));
    checkOutput({tag, ".model_now"}, int'(model_now), mModel);
    checkOutput({tag, ".water_level"}, int'(water_level), mLevel);
    checkOutput({tag, ".power_led"}, int'(power_led), int'(mState != S_OFF));
    checkOutput({tag, ".power_off"}, int'(power_off), int'(mState == S_OFF));
    checkOutput({tag, ".if_finish"}, int'(if_finish), int'(mState >= S_DONE));
    checkOutput({tag, ".buzzer_led"}, int'(buzzer_led), int'(mState == S_DONE));
    checkOutput({tag, ".start_led"}, int'(start_led), int'(run && !mPaused));
    checkOutput({tag, ".wash_led"}, int'(wash_led), int'(run && seg == 0));
    checkOutput({tag, ".rinse_led"}, int'(rinse_led), int'(run && seg == 1));
    checkOutput({tag, ".dry_led"}, int'(dry_led), int'(mState == S_DRY));
    checkOutput({tag, ".in_led"}, int'(in_led), int'(mState == S_FILL));
    checkOutput({tag, ".out_led"}, int'(out_led), int'(mState == S_DRAIN));
  endtask

  // Random button activity: lively while idle, sparse pausing while running.
  task automatic applyStimulus(input bit idle);
    if (idle) begin
      if ($urandom_range(0, 9) == 0) start_pause = ~start_pause;
      if ($urandom_range(0, 2) == 0) module_select = ~module_select;
      if ($urandom_range(0, 2) == 0) water_select = ~water_select;
    end else begin
      if ($urandom_range(0, 29) == 0) start_pause = ~start_pause;
      if ($urandom_range(0, 3) == 0) module_select = ~module_select;
      if ($urandom_range(0, 3) == 0) water_select = ~water_select;
    end
  endtask

  initial begin
    int midReset;
    for (int ep = 0; ep < 20; ep++) begin
      @(negedge clk);
      reset = 1'b0;
      modelReset();
      #1;
      checkAll("reset");
      if (ep == 0) begin
        start_pause = 1'b1; module_select = 1'b0; water_select = 1'b0;
      end else begin
        start_pause = 1'($urandom_range(0, 1));
        module_select = 1'($urandom_range(0, 1));
        water_select = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      reset = 1'b1;
      midReset = (ep % 4 == 3) ? int'($urandom_range(20, 150)) : -1;
      for (int cyc = 0; cyc < 500; cyc++) begin
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkAll("run");
        // Undisturbed default program: fixed timeline from the first edge.
        if (ep == 0) begin
          if (cyc == 0) begin
            checkOutput("first.state", int'(state), 1);
            checkOutput("first.count", int'(count), 4);
            checkOutput("first.time_now", int'(time_now), 29);
            checkOutput("first.in_led", int'(in_led), 1);
            checkOutput("first.start_led", int'(start_led), 1);
          end
          if (cyc == 4) checkOutput("tick4.time_now", int'(time_now), 28);
          if (cyc == 115) checkOutput("c115.state", int'(state), 5);
          if (cyc == 116) begin
            checkOutput("c116.state", int'(state), 6);
            checkOutput("c116.buzzer", int'(buzzer_led), 1);
          end
          if (cyc == 127) checkOutput("c127.state", int'(state), 6);
          if (cyc == 128) begin
            checkOutput("c128.power_off", int'(power_off), 1);
            checkOutput("c128.power_led", int'(power_led), 0);
          end
        end
        if (cyc == midReset) begin
          #2;
          reset = 1'b0;
          #1;
          checkOutput("async.state", int'(state), 0);
          checkOutput("async.model_now", int'(model_now), 0);
          checkOutput("async.water_level", int'(water_level), 4);
          checkOutput("async.power_led", int'(power_led), 1);
          modelReset();
          checkAll("async");
          break;
        end
        if (ep != 0) applyStimulus(mState == S_IDLE);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
